serial_add_ctrl: RTL
====================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset; sampled on rising clk edge only.
REQ-004 start  input  1  request a new addition; accepted only when busy=0.
REQ-005 a  input  WIDTH  operand A, sampled in the accept cycle only.
REQ-006 b  input  WIDTH  operand B, sampled in the accept cycle only.
REQ-007 cin  input  1  carry-in, sampled in the accept cycle only.
REQ-008 busy  output  1  high while an operation is in progress (states RUN and DONE).
REQ-009 done  output  1  single-cycle pulse: sum/cout hold the new result.
REQ-010 sum  output  WIDTH  registered result, a+b+cin modulo 2^WIDTH.
REQ-011 cout  output  1  registered carry-out of the WIDTH-bit addition.

Function
REQ-012 Datapath: one full_adder instance computes one bit per cycle (bit-serial, LSB first); no other adder logic is present.
REQ-013 Internal state: operand shift registers sa/sb (WIDTH), carry flop cr, result shift register sr (WIDTH), bit counter cnt (ceil(log2(WIDTH+1)) bits), FSM.
REQ-014 FSM states: IDLE, RUN, DONE; all outputs come from registers, none from combinational logic on inputs.
REQ-015 IDLE: start=1 -> load sa=a, sb=b, cr=cin, cnt=0; next state RUN. start=0 -> stay in IDLE.
REQ-016 RUN, each cycle: full_adder inputs sa[0], sb[0], cr; shift sa/sb right by 1; cr <= adder carry; shift adder sum into sr MSB (sr right-shifted); cnt <= cnt+1.
REQ-017 RUN exit: in the cycle where cnt = WIDTH-1, the FSM goes to DONE; sum <= final sr value including this bit; cout <= adder carry of this bit.
REQ-018 DONE: done=1 for exactly this cycle; next state IDLE unconditionally.
REQ-019 Latency: start accepted in cycle k -> RUN in cycles k+1..k+WIDTH -> done=1 in cycle k+WIDTH+1 -> busy=0 and new start acceptable in cycle k+WIDTH+2.
REQ-020 start while busy=1, including in the DONE cycle: ignored; no queuing, no effect on the in-flight operation.
REQ-021 Changes on a/b/cin after the accept cycle have no effect on the result.
REQ-022 sum/cout hold their value from the last completed operation until the next DONE; they do not change during RUN.
REQ-023 Wrap-around: the result is modulo 2^WIDTH; overflow is reported only through cout.

Reset
REQ-024 rst=1 at a clock edge -> state IDLE, busy=0, done=0, sum=0, cout=0, sa/sb/sr/cr/cnt=0.
REQ-025 rst has priority over start and over all FSM transitions.
REQ-026 rst in RUN or DONE aborts the operation; no done pulse follows; sum/cout become 0.

Verification
REQ-027 WIDTH=8, a=3, b=5, cin=0, start pulse in cycle k -> busy=1 from k+1; done=1 only in k+9; sum=8, cout=0; busy=0 in k+10.
REQ-028 WIDTH=8, a=255, b=1, cin=0 -> sum=0, cout=1. Then a=255, b=255, cin=1 -> sum=255, cout=1.
REQ-029 Start, then start=1 held every cycle with different a/b -> the first result is unaffected; the next accept happens only in the cycle after done (k+10), giving back-to-back results every 10 cycles.
REQ-030 rst=1 in the 4th RUN cycle -> busy=0, sum=0, cout=0 next cycle; no done pulse within 20 cycles; a fresh start then yields a correct result.
REQ-031 Random a/b/cin (>=1000 ops, WIDTH=8 and WIDTH=2) against a reference model {cout,sum}=a+b+cin; check the exact done cycle and that sum/cout are stable between done pulses.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full_adder, LSB first, WIDTH+1 cycles from accept to done.
// Latency: done pulses WIDTH+1 cycles after the accept cycle. Backpressure: start is ignored while busy.

module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic             r_cr;
    logic [WIDTH-2:0] r_sr;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_fa_s;
    logic             w_fa_c;
    logic [WIDTH-1:0] w_sr_full;

    full_adder u_fa (
        .i_a (r_sa[0]),
        .i_b (r_sb[0]),
        .i_c (r_cr),
        .o_s (w_fa_s),
        .o_c (w_fa_c)
    );

    // The incoming bit is the MSB of the shifted result; the bit falling off
    // the bottom is never needed, so only WIDTH-1 result bits are stored.
    assign w_sr_full = {w_fa_s, r_sr};

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = S_RUN;
            S_RUN:   if (r_cnt == LAST) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sa   <= '0;
            r_sb   <= '0;
            r_cr   <= 1'b0;
            r_sr   <= '0;
            r_cnt  <= '0;
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sa  <= a;
                        r_sb  <= b;
                        r_cr  <= cin;
                        r_cnt <= '0;
                    end
                end
                S_RUN: begin
                    r_sa  <= r_sa >> 1;
                    r_sb  <= r_sb >> 1;
                    r_cr  <= w_fa_c;
                    r_sr  <= w_sr_full[WIDTH-1:1];
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        r_sum  <= w_sr_full;
                        r_cout <= w_fa_c;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);
    assign sum  = r_sum;
    assign cout = r_cout;
endmodule
